// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO access arbiter: FSM state encoding,
// FIFO slave address map, status bit positions and the last-operation flag
// used to alternate push and pop.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ      = 2'd2,
      READ_WAIT = 2'd3
   } state_e;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_e;

   localparam logic [1:0] ADDR_PUSH = 2'd0;
   localparam logic [1:0] ADDR_POP  = 2'd1;

   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       - request vector, one bit per requester
//   rr_ptr    - index where the upward scan starts (wraps at NUM_REQ-1)
//   grant     - one-hot grant of the first asserted request found
//   grant_idx - binary index of that grant
//   any_grant - at least one request is asserted
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_grant
);

   logic [IDX_W-1:0] sel;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      sel       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!any_grant && req[sel]) begin
            any_grant  = 1'b1;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Avalon-MM master sharing one FIFO slave port between NUM_REQ push
// requesters (round-robin) and a single pop consumer. Push and pop alternate
// when both are eligible; accesses are gated on FIFO full/empty.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   req_valid/req_data    - push requests (level) and packed data
//   req_ack               - one-cycle one-hot acceptance pulse
//   pop_req               - pop request (level)
//   pop_valid/pop_data    - popped word strobe and held data
//   grant_id              - index of the last push winner
//   busy                  - FSM not in IDLE
//   avm_*                 - Avalon-MM master towards the FIFO
//   fifo_status           - {full, empty}
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | sample status/requests, pick next access
// WRITE     | push strobe to FIFO, ack the winning requester
// READ      | pop strobe to FIFO
// READ_WAIT | capture avm_readdata, pop_valid follows in IDLE
module fifo_access_arbiter
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int REQ_IDX_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ack,
   input  logic                     pop_req,
   output logic                     pop_valid,
   output logic [WIDTH-1:0]         pop_data,
   output logic [REQ_IDX_W-1:0]     grant_id,
   output logic                     busy,
   output logic [1:0]               avm_address,
   output logic                     avm_write,
   output logic                     avm_read,
   output logic [WIDTH-1:0]         avm_writedata,
   input  logic [WIDTH-1:0]         avm_readdata,
   input  logic [1:0]               fifo_status
);

   state_e                 state_q, state_d;
   op_e                    last_op_q, last_op_d;
   logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [REQ_IDX_W-1:0]   win_q, win_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [1:0]             addr_q, addr_d;
   logic [WIDTH-1:0]       pop_data_q, pop_data_d;
   logic                   pop_valid_q, pop_valid_d;

   logic [NUM_REQ-1:0]     arb_grant;
   logic [REQ_IDX_W-1:0]   arb_idx;
   logic                   arb_any;
   logic [WIDTH-1:0]       arb_data;
   logic                   push_ok, pop_ok;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (REQ_IDX_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_grant (arb_any)
   );

   // AND-OR mux of the winner's data using the one-hot grant
   always_comb begin
      arb_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            arb_data = arb_data | req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign push_ok = arb_any && !fifo_status[STAT_FULL];
   assign pop_ok  = pop_req && !fifo_status[STAT_EMPTY];

   always_comb begin
      state_d     = state_q;
      last_op_d   = last_op_q;
      rr_ptr_d    = rr_ptr_q;
      win_d       = win_q;
      data_d      = data_q;
      addr_d      = addr_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      avm_write   = 1'b0;
      avm_read    = 1'b0;
      req_ack     = '0;
      case (state_q)
         IDLE: begin
            // when both are eligible, take the opposite of the last access
            if (push_ok && (!pop_ok || last_op_q == OP_READ)) begin
               state_d = WRITE;
               win_d   = arb_idx;
               data_d  = arb_data;
               addr_d  = ADDR_PUSH;
            end else if (pop_ok) begin
               state_d = READ;
               addr_d  = ADDR_POP;
            end
         end
         WRITE: begin
            avm_write = 1'b1;
            req_ack   = NUM_REQ'(1) << win_q;
            rr_ptr_d  = (win_q == REQ_IDX_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
            last_op_d = OP_WRITE;
            state_d   = IDLE;
         end
         READ: begin
            avm_read = 1'b1;
            state_d  = READ_WAIT;
         end
         READ_WAIT: begin
            pop_data_d  = avm_readdata;
            pop_valid_d = 1'b1;
            last_op_d   = OP_READ;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_op_q   <= OP_WRITE;
         rr_ptr_q    <= '0;
         win_q       <= '0;
         data_q      <= '0;
         addr_q      <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_op_q   <= last_op_d;
         rr_ptr_q    <= rr_ptr_d;
         win_q       <= win_d;
         data_q      <= data_d;
         addr_q      <= addr_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
      end
   end

   assign pop_valid     = pop_valid_q;
   assign pop_data      = pop_data_q;
   assign grant_id      = win_q;
   assign busy          = (state_q != IDLE);
   assign avm_address   = addr_q;
   assign avm_writedata = data_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Scoreboard bench for fifo_access_arbiter: stimulus pushes expected
// write/pop events into a queue, a negedge monitor pops and compares them
// whenever the DUT strobes avm_write or pop_valid.
module tb_fifo_access_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic        pop_req;
   logic        pop_valid;
   logic [7:0]  pop_data;
   logic [1:0]  grant_id;
   logic        busy;
   logic [1:0]  avm_address;
   logic        avm_write;
   logic        avm_read;
   logic [7:0]  avm_writedata;
   logic [7:0]  avm_readdata;
   logic [1:0]  fifo_status;

   fifo_access_arbiter #(.WIDTH(8), .NUM_REQ(4), .REQ_IDX_W(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .pop_req       (pop_req),
      .pop_valid     (pop_valid),
      .pop_data      (pop_data),
      .grant_id      (grant_id),
      .busy          (busy),
      .avm_address   (avm_address),
      .avm_write     (avm_write),
      .avm_read      (avm_read),
      .avm_writedata (avm_writedata),
      .avm_readdata  (avm_readdata),
      .fifo_status   (fifo_status)
   );

   typedef struct {
      bit         is_pop;
      logic [1:0] idx;
      logic [7:0] data;
      int         gap;   // expected cycles since previous strobe of interest, 0 = unchecked
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   wr_cnt = 0;
   int   rd_cnt = 0;
   int   last_wr_cyc = 0;
   int   last_rd_cyc = 0;
   bit   auto_drop = 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input bit is_pop, input logic [1:0] idx, input logic [7:0] data, input int gap);
      exp_t e;
      e.is_pop = is_pop;
      e.idx    = idx;
      e.data   = data;
      e.gap    = gap;
      q.push_back(e);
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (avm_write && avm_read) chk("strobe_overlap", 1, 0);
         if (req_ack != 4'b0 && !avm_write) chk("stray_ack", {28'b0, req_ack}, 0);
         if (avm_read) begin
            rd_cnt++;
            chk("read_addr", {30'b0, avm_address}, 1);
            last_rd_cyc = cyc;
         end
         if (avm_write) begin
            wr_cnt++;
            chk("write_addr", {30'b0, avm_address}, 0);
            if (q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = q.pop_front();
               chk("op_order_write", {31'b0, e.is_pop}, 0);
               chk("grant_id", {30'b0, grant_id}, {30'b0, e.idx});
               chk("req_ack", {28'b0, req_ack}, {28'b0, 4'b0001 << e.idx});
               chk("writedata", {24'b0, avm_writedata}, {24'b0, e.data});
               if (e.gap > 0) chk("write_spacing", cyc - last_wr_cyc, e.gap);
            end
            last_wr_cyc = cyc;
         end
         if (pop_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_pop", 1, 0);
            end else begin
               e = q.pop_front();
               chk("op_order_pop", {31'b0, e.is_pop}, 1);
               chk("pop_data", {24'b0, pop_data}, {24'b0, e.data});
               if (e.gap > 0) chk("pop_latency", cyc - last_rd_cyc, e.gap);
            end
         end
      end
   end

   // one cycle; requesters drop req_valid after their ack
   task automatic tick();
      logic [3:0] ack_s;
      @(negedge clk);
      ack_s = req_ack;
      @(posedge clk);
      #1;
      if (auto_drop) req_valid = req_valid & ~ack_s;
   endtask

   initial begin
      int  w0;
      int  r0;
      bit  seen;
      reset        = 1'b0;
      req_valid    = 4'b0;
      req_data     = 32'b0;
      pop_req      = 1'b0;
      avm_readdata = 8'h00;
      fifo_status  = 2'b00;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ack", {28'b0, req_ack}, 0);
      chk("rst_pop_valid", {31'b0, pop_valid}, 0);
      chk("rst_pop_data", {24'b0, pop_data}, 0);
      chk("rst_grant_id", {30'b0, grant_id}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_address", {30'b0, avm_address}, 0);
      chk("rst_write", {31'b0, avm_write}, 0);
      chk("rst_read", {31'b0, avm_read}, 0);
      chk("rst_writedata", {24'b0, avm_writedata}, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // all four requesters, round-robin order 0..3 at 2-cycle spacing
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      push_exp(0, 2'd0, 8'h11, 0);
      push_exp(0, 2'd1, 8'h22, 2);
      push_exp(0, 2'd2, 8'h33, 2);
      push_exp(0, 2'd3, 8'h44, 2);
      req_valid = 4'b1111;
      repeat (10) tick();
      chk("rr_all_acked", {28'b0, req_valid}, 0);

      // wrap-around: last winner 3, so 0 then 3
      req_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
      push_exp(0, 2'd0, 8'hD0, 0);
      push_exp(0, 2'd3, 8'hD3, 2);
      req_valid = 4'b1001;
      repeat (6) tick();
      chk("wrap_all_acked", {28'b0, req_valid}, 0);

      // full: no write, no ack until released
      fifo_status = 2'b10;
      req_data    = {8'h00, 8'h00, 8'h61, 8'h00};
      req_valid   = 4'b0010;
      w0 = wr_cnt;
      repeat (6) tick();
      chk("full_no_write", wr_cnt - w0, 0);
      chk("full_no_ack", {28'b0, req_valid}, 32'h2);
      push_exp(0, 2'd1, 8'h61, 0);
      fifo_status = 2'b00;
      seen = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (req_ack[1]) seen = 1;
      end
      chk("ack_after_release", {31'b0, seen}, 1);
      @(posedge clk);
      #1 req_valid = 4'b0;

      // single pop, readdata present only on the cycle after avm_read
      push_exp(1, 2'd0, 8'hA5, 2);
      r0 = rd_cnt;
      pop_req = 1'b1;
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge clk);
         if (avm_read) seen = 1;
      end
      chk("pop_read_seen", {31'b0, seen}, 1);
      @(posedge clk);
      #1;
      avm_readdata = 8'hA5;
      pop_req = 1'b0;
      @(posedge clk);
      #1 avm_readdata = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      chk("single_read", rd_cnt - r0, 1);
      chk("pop_data_hold", {24'b0, pop_data}, 32'hA5);

      // empty: no read
      fifo_status = 2'b01;
      pop_req = 1'b1;
      r0 = rd_cnt;
      repeat (6) @(posedge clk);
      #1;
      chk("empty_no_read", rd_cnt - r0, 0);
      pop_req = 1'b0;
      fifo_status = 2'b00;

      // reset asserted during WRITE
      req_data = {8'h00, 8'h00, 8'h00, 8'h77};
      push_exp(0, 2'd0, 8'h77, 0);
      req_valid = 4'b0001;
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge clk);
         if (avm_write) seen = 1;
      end
      chk("rstw_write_seen", {31'b0, seen}, 1);
      reset = 1'b0;
      req_valid = 4'b0;
      @(negedge clk);
      chk("rstw_write", {31'b0, avm_write}, 0);
      chk("rstw_ack", {28'b0, req_ack}, 0);
      chk("rstw_busy", {31'b0, busy}, 0);
      chk("rstw_grant_id", {30'b0, grant_id}, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // alternation after reset: READ first, then WRITE, READ, ...
      auto_drop = 0;
      avm_readdata = 8'h3C;
      push_exp(1, 2'd0, 8'h3C, 2);
      push_exp(0, 2'd0, 8'h77, 0);
      push_exp(1, 2'd0, 8'h3C, 2);
      push_exp(0, 2'd0, 8'h77, 5);
      push_exp(1, 2'd0, 8'h3C, 2);
      push_exp(0, 2'd0, 8'h77, 5);
      w0 = wr_cnt;
      pop_req = 1'b1;
      req_valid = 4'b0001;
      for (int k = 0; k < 40 && (wr_cnt - w0) < 3; k++) begin
         @(negedge clk);
         #1;
      end
      chk("alt_three_writes", wr_cnt - w0, 3);
      @(posedge clk);
      #1;
      pop_req = 1'b0;
      req_valid = 4'b0;
      avm_readdata = 8'h00;
      auto_drop = 1;
      repeat (3) @(posedge clk);

      // rr_ptr cleared by reset: 0011 grants 0 then 1
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      req_data = {8'h00, 8'h00, 8'h91, 8'h90};
      push_exp(0, 2'd0, 8'h90, 0);
      push_exp(0, 2'd1, 8'h91, 2);
      req_valid = 4'b0011;
      repeat (6) tick();
      chk("rstrr_all_acked", {28'b0, req_valid}, 0);

      repeat (3) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
